par_serial_tx: RTL and testbench



---
 rtl/phy_pkg.sv | 14 +
 rtl/par_serial_tx_if.sv | 11 +
 rtl/par_serial_shreg.sv | 38 +++
 rtl/par_serial_tx.sv | 79 +++++++
 tb/tb_par_serial_tx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/phy_pkg.sv
// Shared PHY constants: comma symbol, link FSM encoding and counter sizing helper.
package phy_pkg;

  localparam int unsigned PHY_WIDTH = 8;
  localparam logic [7:0]  IDLE_K285 = 8'hBC;

  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/par_serial_tx_if.sv
// Ready/valid symbol handshake between the upstream framer and the serializer.
interface par_serial_tx_if import phy_pkg::*; #(
  parameter int unsigned WIDTH = PHY_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input  ready_out);
  modport slave  (input  data_in, input  valid_in, output ready_out);
endinterface

// File: rtl/par_serial_shreg.sv
// Parallel-load shift register with bit counter; reloads on the last bit of each symbol.
module par_serial_shreg import phy_pkg::*; #(
  parameter int unsigned     WIDTH     = PHY_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(IDLE_K285)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_serial,
  output logic             o_symbol_start,
  output logic             o_boundary
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;

  // Shift MSB-first; on the boundary bit restart the counter and load the next symbol.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_shreg   <= IDLE_BYTE;
      r_bit_cnt <= '0;
    end else if (r_bit_cnt == LAST_BIT) begin
      r_shreg   <= i_load_data;
      r_bit_cnt <= '0;
    end else begin
      r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  assign o_serial       = r_shreg[WIDTH-1];
  assign o_symbol_start = (r_bit_cnt == '0);
  assign o_boundary     = (r_bit_cnt == LAST_BIT);

endmodule

// File: rtl/par_serial_tx.sv
// PHY transmit serializer: link-training FSM and symbol handshake around the shift register.
module par_serial_tx import phy_pkg::*; #(
  parameter int unsigned      WIDTH        = PHY_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_BYTE    = WIDTH'(IDLE_K285),
  parameter int unsigned      INIT_SYMBOLS = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          tx_enable,
  par_serial_tx_if.slave bus,
  output logic          serial_out,
  output logic          symbol_start,
  output logic          active
);

  localparam int unsigned       INIT_W    = cnt_width(INIT_SYMBOLS);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_SYMBOLS - 1);

  logic [0:0]        r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic              w_boundary;
  logic              w_ready;
  logic [WIDTH-1:0]  w_load_data;

  // Ready depends only on link state and bit position so upstream never sees a valid-to-ready path.
  assign w_ready      = (r_state == ST_ACTIVE) && w_boundary && tx_enable;
  assign w_load_data  = (bus.valid_in && w_ready) ? bus.data_in : IDLE_BYTE;
  assign bus.ready_out = w_ready;
  assign active        = (r_state == ST_ACTIVE);

  par_serial_shreg #(
    .WIDTH     (WIDTH),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_shreg (
    .clk            (clk),
    .reset_L        (reset_L),
    .i_load_data    (w_load_data),
    .o_serial       (serial_out),
    .o_symbol_start (symbol_start),
    .o_boundary     (w_boundary)
  );

  // Link FSM advances only at symbol boundaries so a symbol is never cut short.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else if (w_boundary) begin
      case (r_state)
        ST_INIT: begin
          if (!tx_enable) begin
            r_init_cnt <= '0;
          end else if (r_init_cnt == INIT_LAST) begin
            r_state    <= ST_ACTIVE;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!tx_enable) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
          end else begin
            r_state    <= ST_ACTIVE;
          end
        end
        default: begin
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
        end
      endcase
    end else begin
      r_state    <= r_state;
      r_init_cnt <= r_init_cnt;
    end
  end

endmodule

// File: tb/tb_par_serial_tx.sv
// Scoreboard bench for par_serial_tx: symbol-level reference model feeds an expectation queue.
module tb_par_serial_tx;

  localparam int         W      = 8;
  localparam logic [7:0] IDLE   = 8'hBC;
  localparam int         INIT_N = 4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic tx_enable = 1'b0;
  logic serial_out, symbol_start, active;

  par_serial_tx_if #(.WIDTH(W)) bus_if ();

  par_serial_tx #(
    .WIDTH        (W),
    .IDLE_BYTE    (IDLE),
    .INIT_SYMBOLS (INIT_N)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .tx_enable    (tx_enable),
    .bus          (bus_if),
    .serial_out   (serial_out),
    .symbol_start (symbol_start),
    .active       (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic serial;
    logic sstart;
    logic act;
    logic rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_xfer_model = 0;
  int         n_xfer_dut   = 0;

  // Reference model: the symbol now on the wire, position in it, and link training progress.
  logic [W-1:0] m_sym;
  int           m_phase;
  int           m_trained;
  bit           m_active;
  logic [W-1:0] pend_data;

  task automatic check(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] next_data();
    if (data_q.size() > 0) return data_q.pop_front();
    return W'($urandom);
  endfunction

  task automatic model_reset();
    m_sym     = IDLE;
    m_phase   = 0;
    m_trained = 0;
    m_active  = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive inputs, record what this cycle must look like, advance the model.
  task automatic step(input bit en, input bit vld);
    exp_t e;
    bit   last;
    tx_enable       = en;
    bus_if.valid_in = vld;
    bus_if.data_in  = pend_data;
    last     = (m_phase == W - 1);
    e.serial = m_sym[W-1-m_phase];
    e.sstart = (m_phase == 0);
    e.act    = m_active;
    e.rdy    = m_active && last && en;
    exp_q.push_back(e);
    if (last) begin
      if (e.rdy && vld) begin
        m_sym = pend_data;
        n_xfer_model++;
        pend_data = next_data();
      end else begin
        m_sym = IDLE;
      end
      if (m_active) begin
        if (!en) begin
          m_active  = 1'b0;
          m_trained = 0;
        end
      end else if (en) begin
        m_trained++;
        if (m_trained == INIT_N) begin
          m_active  = 1'b1;
          m_trained = 0;
        end
      end else begin
        m_trained = 0;
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges: outputs must take reset values without waiting for a clock.
  task automatic do_reset();
    logic [7:0] idle_v;
    idle_v  = IDLE;
    reset_L = 1'b0;
    #1;
    check("rst_serial", serial_out, idle_v[W-1]);
    check("rst_sstart", symbol_start, 1'b1);
    check("rst_ready", bus_if.ready_out, 1'b0);
    check("rst_active", active, 1'b0);
    model_reset();
    @(posedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  // Monitor: compare every sampled cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_L && bus_if.valid_in && bus_if.ready_out) n_xfer_dut++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("serial_out", serial_out, e.serial);
        check("symbol_start", symbol_start, e.sstart);
        check("active", active, e.act);
        check("ready_out", bus_if.ready_out, e.rdy);
      end
    end
  end

  initial begin
    bit en;
    bus_if.valid_in = 1'b0;
    bus_if.data_in  = '0;
    pend_data       = IDLE;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset_L = 1'b1;

    // Training burst and idle fill with no traffic.
    repeat (60) step(1'b1, 1'b0);

    // Data presented from the first cycle must wait for the first ready.
    step(1'b1, 1'b0);
    do_reset();
    pend_data = 8'hA5;
    repeat (56) step(1'b1, 1'b1);

    // Back-to-back stream with boundary values.
    data_q.push_back(8'h80);
    data_q.push_back(8'hFF);
    data_q.push_back(8'h3C);
    pend_data = 8'h01;
    repeat (32) step(1'b1, 1'b1);
    data_q.push_back(8'hC3);
    repeat (8) step(1'b1, 1'b0);
    repeat (16) step(1'b1, 1'b1);

    // Drop tx_enable mid-symbol, then retrain.
    while (m_phase != 4) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    repeat (60) step(1'b1, 1'b1);

    // Reset in the middle of a data symbol, then restart from scratch.
    while (!(m_active && m_phase == 3)) step(1'b1, 1'b1);
    do_reset();
    repeat (60) step(1'b1, 1'b0);

    // Randomized traffic, enable toggles and occasional resets.
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) do_reset();
      step(en, ($urandom_range(0, 99) < 70));
    end

    @(negedge clk);
    #1;
    check("transfer_count", (n_xfer_dut == n_xfer_model), 1'b1);
    if (n_xfer_dut != n_xfer_model)
      $display("FAIL xfer_total: got %0d, expected %0d", n_xfer_dut, n_xfer_model);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
